// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin scheduler in front of the 6x6/3x3 LCD display
// controller. Two command sources compete for the controller; the winner's
// command is issued on cmd/cmd_valid/busy. The winner's 36 pixel bytes are
// streamed during a Load. The 9 window bytes come back tagged with the
// winner's ID.
//
// Handshakes:
//   reqN_valid/reqN_ready -- a command moves when both are high in the same
//   cycle. Ready is combinational. It is offered only in IDLE while the
//   controller is not busy, and only to the round-robin winner. Valid may
//   drop without a transfer; arbitration state does not move unless a
//   transfer happens.
//   lcd_cmd_valid/lcd_busy -- a command is presented for exactly one cycle,
//   and only while the controller reports not busy.
//   ld_popN/reqN_data -- first-word-fall-through. The byte on reqN_data is
//   consumed in every cycle ld_popN is high.
//
// Debug visibility: the FSM state is held in state_q (type state_t) so that
// external checkers can bind to it.

module lcd_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_cmd,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  output logic       ld_pop0,
  input  logic       req1_valid,
  input  logic [2:0] req1_cmd,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  output logic       ld_pop1,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  output logic [7:0] lcd_datain,
  input  logic [7:0] lcd_dataout,
  input  logic       lcd_output_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_last,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [2:0] CMD_LOAD   = 3'd1;
  localparam logic [5:0] LOAD_LAST  = 6'd35;
  localparam logic [3:0] BEATS_FULL = 4'd9;
  localparam logic [3:0] BEAT_SAT   = 4'd15;
  localparam logic [8:0] WD_LIM     = 9'(TIMEOUT);
  localparam logic [8:0] WD_LAST    = 9'(TIMEOUT - 1);

  state_t     state_q;
  logic       rr_q;         // requester that currently holds priority
  logic       owner_q;      // requester owning the current transaction
  logic [2:0] cmd_q;
  logic [5:0] ld_cnt_q;
  logic [3:0] beat_q;
  logic [8:0] wd_q;
  logic       seen_busy_q;

  logic       arb_open;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [2:0] acc_cmd;
  logic       acc_illegal;
  logic       in_load;
  logic       in_wait;
  logic       live;
  logic       wd_expire;
  logic       wait_done;
  logic       timeout;
  logic       beat;
  logic [3:0] beat_inc;
  logic [8:0] wd_inc;

  // Arbitration: only one grant per cycle. The requester granted last loses ties.
  always_comb begin
    arb_open    = (state_q == ST_IDLE) && !lcd_busy;
    grant0      = arb_open && req0_valid && (!req1_valid || !rr_q);
    grant1      = arb_open && req1_valid && (!req0_valid ||  rr_q);
    accept      = grant0 || grant1;
    acc_cmd     = grant1 ? req1_cmd : req0_cmd;
    acc_illegal = acc_cmd[2] && acc_cmd[1];
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Controller-facing command and load-byte path. The load bytes are a pure
  // mux, so byte k reaches the controller in the same cycle it is popped.
  always_comb begin
    in_load       = (state_q == ST_LOAD);
    in_wait       = (state_q == ST_WAIT);
    lcd_cmd_valid = (state_q == ST_ISSUE) && !lcd_busy;
    lcd_cmd       = lcd_cmd_valid ? cmd_q : 3'd0;
    ld_pop0       = in_load && !owner_q;
    ld_pop1       = in_load &&  owner_q;
    lcd_datain    = in_load ? (owner_q ? req1_data : req0_data) : 8'd0;
  end

  // Transaction-end conditions. A normal completion wins over a watchdog
  // expiry in the same cycle, because the transaction did finish.
  always_comb begin
    live      = in_load || in_wait;
    wd_expire = live && (wd_q == WD_LAST);
    wait_done = in_wait && seen_busy_q && !lcd_busy;
    timeout   = wd_expire && !wait_done;
    beat      = in_wait && lcd_output_valid && !timeout;
    beat_inc  = (beat && (beat_q != BEAT_SAT)) ? beat_q + 4'd1 : beat_q;
    wd_inc    = (wd_q != WD_LIM) ? wd_q + 9'd1 : wd_q;
  end

  // Main FSM together with its registered outputs (rsp_*, err).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cmd_q       <= 3'd0;
      ld_cnt_q    <= 6'd0;
      beat_q      <= 4'd0;
      wd_q        <= 9'd0;
      seen_busy_q <= 1'b0;
      rsp_data    <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_last    <= 1'b0;
      err         <= 1'b0;
    end else begin
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant1;
            cmd_q   <= acc_cmd;
            rr_q    <= ~grant1;
            if (acc_illegal) begin
              // An illegal code is consumed and reported, nothing is forwarded.
              err <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              beat_q      <= 4'd0;
              seen_busy_q <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (!lcd_busy) begin
            wd_q     <= 9'd0;
            ld_cnt_q <= 6'd0;
            state_q  <= (cmd_q == CMD_LOAD) ? ST_LOAD : ST_WAIT;
          end
        end
        ST_LOAD: begin
          wd_q <= wd_inc;
          if (lcd_busy) begin
            seen_busy_q <= 1'b1;
          end
          if (timeout) begin
            err     <= 1'b1;
            state_q <= ST_IDLE;
          end else if (ld_cnt_q == LOAD_LAST) begin
            state_q <= ST_WAIT;
          end
          ld_cnt_q <= ld_cnt_q + 6'd1;
        end
        ST_WAIT: begin
          wd_q <= wd_inc;
          if (lcd_busy) begin
            seen_busy_q <= 1'b1;
          end
          if (beat) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lcd_dataout;
            rsp_id    <= owner_q;
            rsp_last  <= (beat_q == BEATS_FULL - 4'd1);
          end
          beat_q <= beat_inc;
          if (wait_done) begin
            state_q <= ST_IDLE;
            err     <= (beat_inc != BEATS_FULL);
          end else if (timeout) begin
            err     <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Testbench for lcd_cmd_arbiter. A controller stub runs a per-cycle busy/beat
// script for every issued command. The reference model tracks transactions
// at the level of "who may be granted, what must be issued, which bytes must
// be streamed, which beats must come back and when an error is owed".
module tb_lcd_cmd_arbiter;

  localparam int TIMEOUT  = 255;
  localparam int LOAD_LEN = 36;
  localparam int BEATS    = 9;
  localparam logic [7:0] BASE0 = 8'h80;
  localparam logic [7:0] BASE1 = 8'h00;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_cmd = 3'd0, req1_cmd = 3'd0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic       req0_ready, req1_ready, ld_pop0, ld_pop1;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy = 1'b0;
  logic [7:0] lcd_datain;
  logic [7:0] lcd_dataout = 8'd0;
  logic       lcd_output_valid = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_valid, rsp_id, rsp_last, err;

  always #5 clk = ~clk;

  lcd_cmd_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req0_data(req0_data), .ld_pop0(ld_pop0),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .req1_data(req1_data), .ld_pop1(ld_pop1),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_busy(lcd_busy),
    .lcd_datain(lcd_datain), .lcd_dataout(lcd_dataout),
    .lcd_output_valid(lcd_output_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .err(err)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int cmdq0[$], cmdq1[$];      // pending commands per requester
  int pops0 = 0, pops1 = 0;    // bytes consumed per requester (expected)
  int obs_pop0 = 0, obs_pop1 = 0, obs_cv = 0, err_seen = 0, last_seen = 0;
  int grant_log[$];
  logic [1:0] stub_q[$];       // {busy, output_valid} per cycle
  int  stub_gap_max = 3;
  int  stub_beats = BEATS;
  bit  stub_stuck = 1'b0;

  // reference model
  bit         m_prio, m_free, m_issue_pend, m_live, m_seen_busy, m_owner;
  logic [2:0] m_cmd;
  int         m_live_cnt, m_load_left, m_beats;
  logic [9:0] exp_q[$];        // {id, last, data}

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    req0_valid = (cmdq0.size() > 0);
    req1_valid = (cmdq1.size() > 0);
    req0_cmd   = req0_valid ? 3'(cmdq0[0]) : 3'd0;
    req1_cmd   = req1_valid ? 3'(cmdq1[0]) : 3'd0;
    req0_data  = BASE0 + 8'(pops0);
    req1_data  = BASE1 + 8'(pops1);
  endtask

  task automatic model_reset();
    m_prio = 1'b0; m_free = 1'b1; m_issue_pend = 1'b0; m_live = 1'b0;
    m_seen_busy = 1'b0; m_owner = 1'b0; m_cmd = 3'd0;
    m_live_cnt = 0; m_load_left = 0; m_beats = 0;
    exp_q.delete();
  endtask

  task automatic build_stub_script(input logic [2:0] cmd);
    if (stub_stuck) begin
      repeat (TIMEOUT + 40) stub_q.push_back(2'b10);
    end else begin
      if (cmd == 3'd1) repeat (LOAD_LEN) stub_q.push_back(2'b10);
      repeat ($urandom_range(1, stub_gap_max)) stub_q.push_back(2'b10);
      for (int b = 0; b < stub_beats; b++) begin
        stub_q.push_back(2'b11);
        if ($urandom_range(0, 3) == 0) stub_q.push_back(2'b10);
      end
    end
  endtask

  // One clock cycle: check combinational outputs against the model, cross the
  // edge, check registered outputs, then advance model, stub and requesters.
  task automatic cycle();
    logic e_r0, e_r1, e_cv, e_pop, nexit, tmo, beat, e_err, acc, acc_id;
    logic [2:0] acc_cmd;
    logic [7:0] e_din;
    logic [9:0] e_rsp;
    #2;
    e_r0 = m_free && !lcd_busy && req0_valid && (!req1_valid || !m_prio);
    e_r1 = m_free && !lcd_busy && req1_valid && (!req0_valid ||  m_prio);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    e_cv = m_issue_pend && !lcd_busy;
    chk("lcd_cmd_valid", lcd_cmd_valid, e_cv);
    if (e_cv) chk("lcd_cmd", lcd_cmd, m_cmd);
    e_pop = m_live && (m_load_left > 0);
    chk("ld_pop0", ld_pop0, e_pop && !m_owner);
    chk("ld_pop1", ld_pop1, e_pop && m_owner);
    e_din = !e_pop ? 8'h00 : (m_owner ? BASE1 + 8'(pops1) : BASE0 + 8'(pops0));
    chk("lcd_datain", lcd_datain, e_din);
    if (ld_pop0 === 1'b1) obs_pop0++;
    if (ld_pop1 === 1'b1) obs_pop1++;
    if (lcd_cmd_valid === 1'b1) obs_cv++;

    if (m_live) m_live_cnt++;
    nexit = m_live && (m_load_left == 0) && m_seen_busy && !lcd_busy;
    tmo   = m_live && !nexit && (m_live_cnt >= TIMEOUT);
    beat  = m_live && (m_load_left == 0) && !tmo && lcd_output_valid;
    if (beat) begin
      m_beats++;
      exp_q.push_back({m_owner, (m_beats == BEATS), lcd_dataout});
    end
    acc    = e_r0 || e_r1;
    acc_id = e_r1;
    acc_cmd = 3'd0;
    if (acc) acc_cmd = acc_id ? 3'(cmdq1[0]) : 3'(cmdq0[0]);
    e_err = tmo || (nexit && (m_beats != BEATS)) || (acc && (acc_cmd >= 3'd6));

    @(posedge clk);
    #1;
    chk("err", err, e_err);
    chk("rsp_valid", rsp_valid, beat);
    if (beat) begin
      e_rsp = exp_q.pop_front();
      chk("rsp_id", rsp_id, e_rsp[9]);
      chk("rsp_last", rsp_last, e_rsp[8]);
      chk("rsp_data", rsp_data, e_rsp[7:0]);
    end else begin
      chk("rsp_last_idle", rsp_last, 1'b0);
    end
    if (err === 1'b1) err_seen++;
    if (rsp_last === 1'b1) last_seen++;

    // model advance
    if (e_pop) begin
      if (m_owner) pops1++; else pops0++;
      m_load_left--;
    end
    if (m_live && lcd_busy) m_seen_busy = 1'b1;
    if (nexit || tmo) begin
      m_live = 1'b0;
      m_free = 1'b1;
    end
    if (e_cv) begin
      m_issue_pend = 1'b0;
      m_live = 1'b1;
      m_live_cnt = 0;
      m_load_left = (m_cmd == 3'd1) ? LOAD_LEN : 0;
      m_seen_busy = 1'b0;
      build_stub_script(m_cmd);
    end
    if (acc) begin
      grant_log.push_back(int'(acc_id));
      m_prio = !acc_id;
      if (acc_id) void'(cmdq1.pop_front()); else void'(cmdq0.pop_front());
      if (acc_cmd < 3'd6) begin
        m_free = 1'b0;
        m_issue_pend = 1'b1;
        m_cmd = acc_cmd;
        m_owner = acc_id;
        m_beats = 0;
      end
    end
    // stub and requesters for the next cycle
    if (stub_q.size() > 0) begin
      {lcd_busy, lcd_output_valid} = stub_q.pop_front();
    end else begin
      lcd_busy = 1'b0;
      lcd_output_valid = 1'b0;
    end
    lcd_dataout = 8'($urandom);
    drive_reqs();
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while ((cmdq0.size() > 0 || cmdq1.size() > 0 || !m_free || m_issue_pend ||
            m_live || stub_q.size() > 0 || lcd_busy) && n < max) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < max) else begin
      errors++;
      $error("FAIL %s: still busy after %0d cycles", tag, max);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cmdq0.delete(); cmdq1.delete(); stub_q.delete();
    lcd_busy = 1'b0; lcd_output_valid = 1'b0;
    drive_reqs();
    @(posedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_ld_pop0", ld_pop0, 1'b0);
    chk("rst_ld_pop1", ld_pop1, 1'b0);
    chk("rst_lcd_cmd", lcd_cmd, 3'd0);
    chk("rst_lcd_cmd_valid", lcd_cmd_valid, 1'b0);
    chk("rst_lcd_datain", lcd_datain, 8'd0);
    chk("rst_rsp_data", rsp_data, 8'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_err", err, 1'b0);
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // global time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int gl, cv0, r;
    model_reset();
    do_reset(3);

    // reflash from req0
    gl = grant_log.size(); err_seen = 0; last_seen = 0; cv0 = obs_cv;
    cmdq0.push_back(0); drive_reqs();
    run_idle("reflash", 200);
    chk("reflash_grant", grant_log[gl], 0);
    chk("reflash_cmd_valid_count", obs_cv - cv0, 1);
    chk("reflash_last_count", last_seen, 1);
    chk("reflash_err_count", err_seen, 0);

    // load from req1, bytes 0..35
    gl = grant_log.size(); last_seen = 0; obs_pop0 = 0; obs_pop1 = 0;
    cmdq1.push_back(1); drive_reqs();
    run_idle("load", 300);
    chk("load_grant", grant_log[gl], 1);
    chk("load_pop1_count", obs_pop1, LOAD_LEN);
    chk("load_pop0_count", obs_pop0, 0);
    chk("load_last_count", last_seen, 1);

    // contention: both requesters hold valid for four transactions
    gl = grant_log.size(); last_seen = 0; err_seen = 0;
    cmdq0.push_back(2); cmdq0.push_back(4);
    cmdq1.push_back(3); cmdq1.push_back(5);
    drive_reqs();
    run_idle("contention", 400);
    for (int i = 0; i < 4; i++) chk($sformatf("contention_grant%0d", i), grant_log[gl + i], i % 2);
    chk("contention_last_count", last_seen, 4);
    chk("contention_err_count", err_seen, 0);

    // illegal command, then simultaneous request
    gl = grant_log.size(); err_seen = 0; cv0 = obs_cv;
    cmdq0.push_back(6); drive_reqs();
    run_idle("illegal", 20);
    chk("illegal_grant", grant_log[gl], 0);
    chk("illegal_err_count", err_seen, 1);
    chk("illegal_no_cmd", obs_cv - cv0, 0);
    cmdq0.push_back(0); cmdq1.push_back(0); drive_reqs();
    run_idle("after_illegal", 300);
    chk("after_illegal_grant", grant_log[gl + 1], 1);

    // randomized traffic
    repeat (24) begin
      r = $urandom_range(1, 3);
      stub_gap_max = $urandom_range(1, 6);
      if (r[0]) cmdq0.push_back($urandom_range(0, 7));
      if (r[1]) cmdq1.push_back($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) cmdq1.push_back($urandom_range(0, 5));
      drive_reqs();
      run_idle("random", 600);
    end
    stub_gap_max = 3;

    // controller returns only 8 beats
    err_seen = 0; last_seen = 0; stub_beats = 8;
    cmdq1.push_back(3); drive_reqs();
    run_idle("short_beats", 200);
    stub_beats = BEATS;
    chk("short_err_count", err_seen, 1);
    chk("short_last_count", last_seen, 0);

    // controller stuck busy: watchdog abort, then back to accepting
    err_seen = 0; stub_stuck = 1'b1;
    cmdq0.push_back(0); drive_reqs();
    run_idle("stuck_busy", 600);
    stub_stuck = 1'b0;
    chk("stuck_err_count", err_seen, 1);
    gl = grant_log.size(); last_seen = 0;
    cmdq1.push_back(2); drive_reqs();
    run_idle("after_stuck", 200);
    chk("after_stuck_grants", grant_log.size() - gl, 1);
    chk("after_stuck_last", last_seen, 1);

    // reset in the middle of a load from req0, then both request
    gl = grant_log.size();
    cmdq0.push_back(1); drive_reqs();
    repeat (12) cycle();
    chk("midload_popping", obs_pop0 > 0, 1'b1);
    do_reset(3);
    cmdq0.push_back(0); cmdq1.push_back(0); drive_reqs();
    run_idle("after_reset", 300);
    chk("midload_grant", grant_log[gl], 0);
    chk("after_reset_grant", grant_log[gl + 1], 0);
    chk("after_reset_second", grant_log[gl + 2], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Two-requester command scheduler in front of the 6x6-buffer / 3x3-window LCD display controller. Arbitrates round-robin between two command sources and issues one command at a time on the controller's `cmd`/`cmd_valid`/`busy` handshake. Streams the owner's 36 pixel bytes during a Load, and returns the 9 window bytes tagged with the owner ID. Sits between the host-side command sources and the display controller; it is the controller's only driver.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in LOAD+WAIT before a transaction is aborted. Must fit in 9 bits.
- `clk` in 1: clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): requester N has a command pending.
- `reqN_cmd` in 3: command code. 0 = reflash, 1 = load, 2/3/4/5 = shift right/left/up/down. 6 and 7 are illegal.
- `reqN_ready` out 1: accept. The command transfers on `reqN_valid && reqN_ready`.
- `reqN_data` in 8: load byte from requester N. It is first-word-fall-through and must be valid whenever `ld_popN` is high.
- `ld_popN` out 1: consumes `reqN_data` this cycle. The requester advances to the next byte on the following cycle.
- `lcd_cmd` out 3, `lcd_cmd_valid` out 1: command to the controller.
- `lcd_busy` in 1: controller busy.
- `lcd_datain` out 8: load byte to the controller.
- `lcd_dataout` in 8, `lcd_output_valid` in 1: window bytes from the controller.
- `rsp_data` out 8, `rsp_valid` out 1, `rsp_id` out 1, `rsp_last` out 1: response stream back to the requesters.
- `err` out 1: one-cycle pulse on an illegal command, a timeout, or a wrong beat count.

## Operation
**States:** IDLE, ISSUE, LOAD, WAIT.

**IDLE**
- When `lcd_busy==0` and any `reqN_valid` is high, grant exactly one requester. `reqN_ready` is combinational and high only in IDLE, only for the winner.
- Round-robin: the last-granted requester has low priority. After reset requester 0 has priority.
- On accept: latch the cmd and owner, and update the round-robin pointer.
- Illegal cmd (6/7): pulse `err` next cycle, stay in IDLE, forward nothing.
- Legal cmd: go to ISSUE.

**ISSUE**
- `lcd_cmd_valid=1` and `lcd_cmd`=the latched cmd, for exactly one cycle. This holds only if `lcd_busy==0`; otherwise hold ISSUE with `lcd_cmd_valid=0`.
- Next state is LOAD if cmd==1, else WAIT.

**LOAD**
- Runs for exactly 36 cycles, driven by a 6-bit counter 0..35.
- `ld_pop<owner>=1` every cycle.
- `lcd_datain` = owner's `reqN_data`, combinational mux. It is 0 in every other state.
- On counter==35, go to WAIT.

**WAIT**
- Each `lcd_output_valid` beat is registered onto `rsp_data`/`rsp_valid` with `rsp_id`=owner, and increments a 4-bit beat counter.
- `rsp_last=1` on beat 9.
- When `lcd_busy` is low after having been seen high (a seen-busy flag is set in LOAD/WAIT), go to IDLE.
- If the beat count is not 9 at that point, pulse `err`.

**Watchdog**
- A 9-bit counter clears on ISSUE exit and counts in LOAD and WAIT.
- On reaching `TIMEOUT`: pulse `err`, drop to IDLE, and forward no further beats for that transaction.

**Width rules**
- Counters saturate: the beat counter at 15 and the watchdog at `TIMEOUT`.
- The round-robin pointer is 1 bit.

## Timing
- Reset value of every output is 0. Internal state after reset: IDLE, RR pointer=0, all counters=0, seen-busy=0.
- Reset mid-transaction aborts the transaction immediately. There is no error pulse and no further pops.
- Accept at cycle T puts `lcd_cmd_valid` at T+1, when `lcd_busy` is low.
- Load: `ld_pop`/`lcd_datain` are active T+2..T+37. Byte k (k=0..35) is on `lcd_datain` at T+2+k, which is the cycle the controller samples it.
- `rsp_valid` is `lcd_output_valid` delayed by one cycle, beat for beat.
- `reqN_ready` stays low from T+1 until the cycle after WAIT exits. The minimum issue interval is therefore one controller transaction plus 2 cycles.
- Simultaneous `req0_valid` and `req1_valid`: only one grant per IDLE cycle. Back-to-back contention alternates 0,1,0,1.
- A requester may drop `reqN_valid` without acceptance. The RR pointer does not change unless a grant occurs.

## Test plan
- **Reset:** hold `reset` 3 cycles mid-load.
  - All outputs are 0 on the cycle after the reset edge.
  - First grant after reset goes to req0 when both request.
- **Reflash from req0 at T:**
  - `req0_ready=1` at T.
  - `lcd_cmd_valid=1`, `lcd_cmd=0` at T+1 only.
  - 9 `rsp_valid` beats with `rsp_id=0`, data matching `lcd_dataout` one cycle later.
  - `rsp_last` on the 9th beat; `err` stays 0.
- **Load from req1, bytes 0..35:**
  - `ld_pop1` high exactly T+2..T+37, with `lcd_datain`=0,1,…,35 in order.
  - `ld_pop0` never high.
  - Then 9 beats with `rsp_id=1`.
- **Contention:** req0 and req1 both hold valid for 4 transactions (shift right, left, up, down).
  - Grants go 0,1,0,1.
  - No `lcd_cmd_valid` while `lcd_busy=1`.
- **Illegal cmd:** req0 sends cmd=6.
  - `req0_ready` pulse, then `err=1` for one cycle.
  - No `lcd_cmd_valid`.
  - A following simultaneous request grants req1.
- **Faulty controller stub:**
  - Stub holds `lcd_busy=1` forever: `err` pulses after `TIMEOUT` cycles and the block is back in IDLE.
  - Stub emits 8 beats, then drops `busy`: `err` pulses and `rsp_last` never asserts.
